// File: rtl/sub_adder_unit_if.sv
// Operand/result bus for sub_adder_unit: operands and mode in, registered result and flags out,
// each direction with its own valid/ready pair.
interface sub_adder_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] OUT;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output A, B, sub, in_valid, out_ready,
    input  in_ready, OUT, cout, ovf, zero, out_valid
  );

  modport slave (
    input  A, B, sub, in_valid, out_ready,
    output in_ready, OUT, cout, ovf, zero, out_valid
  );
endinterface

// File: rtl/sub_adder_unit.sv
// Registered two's-complement add/subtract unit built from 4-bit carry-lookahead groups,
// holding one result plus carry, overflow and zero flags behind a valid/ready handshake.
module sub_adder_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  sub_adder_unit_if.slave bus
);

  localparam int unsigned NumGrp = WIDTH / 4;
  localparam int unsigned Msb    = WIDTH - 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("sub_adder_unit: WIDTH must be a multiple of 4 and at least 4");
  end

  // Datapath: subtraction is A + ~B + 1, so sub doubles as the carry-in.
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] sum;
  logic [NumGrp:0]  grp_carry;

  assign bx           = bus.sub ? ~bus.B : bus.B;
  assign gen          = bus.A & bx;
  assign prop         = bus.A ^ bx;
  assign grp_carry[0] = bus.sub;

  for (genvar gi = 0; gi < NumGrp; gi++) begin : g_cla
    localparam int unsigned Lsb = 4 * gi;

    logic [3:0] gg;
    logic [3:0] pp;
    logic [4:0] cc;

    assign gg    = gen[Lsb +: 4];
    assign pp    = prop[Lsb +: 4];
    assign cc[0] = grp_carry[gi];

    // Every internal carry is a flat function of the group carry-in, not a ripple.
    assign cc[1] = gg[0]
                 | (pp[0] & cc[0]);
    assign cc[2] = gg[1]
                 | (pp[1] & gg[0])
                 | (pp[1] & pp[0] & cc[0]);
    assign cc[3] = gg[2]
                 | (pp[2] & gg[1])
                 | (pp[2] & pp[1] & gg[0])
                 | (pp[2] & pp[1] & pp[0] & cc[0]);
    assign cc[4] = gg[3]
                 | (pp[3] & gg[2])
                 | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0])
                 | (pp[3] & pp[2] & pp[1] & pp[0] & cc[0]);

    assign sum[Lsb +: 4]     = pp ^ cc[3:0];
    assign grp_carry[gi + 1] = cc[4];
  end

  logic cout_d;
  logic ovf_d;
  logic zero_d;

  assign cout_d = grp_carry[NumGrp];
  assign ovf_d  = (bus.A[Msb] == bx[Msb]) && (sum[Msb] != bus.A[Msb]);
  assign zero_d = (sum == '0);

  // Output register and handshake.
  logic [WIDTH-1:0] out_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             valid_q;
  logic             valid_d;
  logic             in_ready;
  logic             accept;

  assign in_ready = !rst && (!valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    if (accept) begin
      valid_d = 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        out_q  <= sum;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.OUT       = out_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_sub_adder_unit.sv
// Bench for sub_adder_unit: an arithmetic reference model checked against the DUT every cycle,
// plus hand-computed directed cases, backpressure, async reset, streaming and random traffic.
module tb_sub_adder_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sub_adder_unit_if #(.WIDTH(W)) bus ();

  sub_adder_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: plain wide integer arithmetic, result packed as {ovf, cout, value}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    logic [W:0] u;
    longint     sa;
    longint     sb;
    longint     sr;
    longint     lim;
    logic       c;
    logic       v;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    if (s) begin
      u  = {1'b0, a} - {1'b0, b};
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b};
      c  = u[W];
      sr = sa + sb;
    end
    v = (sr >= lim) || (sr < -lim);
    return {v, c, u[W-1:0]};
  endfunction

  logic [W-1:0] m_out   = '0;
  logic         m_cout  = 1'b0;
  logic         m_ovf   = 1'b0;
  logic         m_zero  = 1'b0;
  logic         m_valid = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [W+1:0] r;
    if (rst) begin
      m_out   <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
      m_zero  <= 1'b0;
      m_valid <= 1'b0;
    end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
      r       = ref_op(bus.A, bus.B, bus.sub);
      m_out   <= r[W-1:0];
      m_cout  <= r[W];
      m_ovf   <= r[W+1];
      m_zero  <= (r[W-1:0] == '0);
      m_valid <= 1'b1;
    end else if (bus.out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  32'(bus.in_ready),  32'(!rst && (!m_valid || bus.out_ready)));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("OUT",       bus.OUT,            m_out);
    chk("cout",      32'(bus.cout),      32'(m_cout));
    chk("ovf",       32'(bus.ovf),       32'(m_ovf));
    chk("zero",      32'(bus.zero),      32'(m_zero));
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic v, input logic r);
    bus.A         = a;
    bus.B         = b;
    bus.sub       = s;
    bus.in_valid  = v;
    bus.out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] eo, input logic ec, input logic ev,
                          input logic ez);
    drive(a, b, s, 1'b1, 1'b1);
    step();
    chk("dir_valid", 32'(bus.out_valid), 32'(1));
    chk("dir_OUT",   bus.OUT,            eo);
    chk("dir_cout",  32'(bus.cout),      32'(ec));
    chk("dir_ovf",   32'(bus.ovf),       32'(ev));
    chk("dir_zero",  32'(bus.zero),      32'(ez));
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'(0));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_OUT",       bus.OUT,            32'h0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(bus.in_ready), 32'(1));

    directed(32'd10,        32'd3,  1'b1, 32'd7,         1'b1, 1'b0, 1'b0);
    directed(32'd3,         32'd10, 1'b1, 32'hFFFF_FFF9, 1'b0, 1'b0, 1'b0);
    directed(32'h8000_0000, 32'd1,  1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed(32'd5,         32'd5,  1'b1, 32'h0,         1'b1, 1'b0, 1'b1);
    directed(32'hFFFF_FFFF, 32'd1,  1'b0, 32'h0,         1'b1, 1'b0, 1'b1);
    directed(32'h7FFF_FFFF, 32'd1,  1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    // Backpressure: held result must survive new operands until consumed.
    drive(32'd20, 32'd4, 1'b1, 1'b1, 1'b1);
    step();
    chk("bp_OUT", bus.OUT, 32'd16);
    for (int k = 0; k < 3; k++) begin
      drive($urandom, $urandom, 1'($urandom % 2), 1'b1, 1'b0);
      #1 chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
      step();
      chk("bp_hold_OUT",   bus.OUT,            32'd16);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'(1));
    end
    drive(32'd100, 32'd1, 1'b1, 1'b1, 1'b1);
    #1 chk("bp_release_in_ready", 32'(bus.in_ready), 32'(1));
    step();
    chk("bp_next_OUT",   bus.OUT,            32'd99);
    chk("bp_next_valid", 32'(bus.out_valid), 32'(1));
    bus.in_valid = 1'b0;

    // Asynchronous reset mid-cycle while a result is held.
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("arst_OUT",       bus.OUT,            32'h0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'(0));
    rst = 1'b0;

    // Streaming: one result per cycle, in order.
    for (int i = 1; i <= 8; i++) begin
      drive(32'(i * 7), 32'(i), 1'b1, 1'b1, 1'b1);
      step();
      chk("stream_valid", 32'(bus.out_valid), 32'(1));
      chk("stream_OUT",   bus.OUT,            32'(i * 6));
    end
    bus.in_valid = 1'b0;

    repeat (2000) begin
      drive(pick(), pick(), 1'($urandom % 2), ($urandom % 4) != 0, ($urandom % 3) != 0);
      step();
    end

    drive('0, '0, 1'b0, 1'b0, 1'b1);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
